collision_probe: RTL
====================

Name: collision_probe

Overview:
- Initiator for the level map's collision read port.
- On a start pulse, takes the player box position and a proposed signed move, then drives the tile query coordinates to the four box corners one per cycle.
- Samples the map's solid bit for each corner and reports per-corner and per-edge hits to the player movement logic.
- Sits between player physics and the level map's second (collision) port.

Parameters:
- BOX_W, 32, player box width in pixels; corners at x and x+BOX_W-1.
- BOX_H, 32, player box height in pixels; corners at y and y+BOX_H-1.

Ports:
- clk  input  1  system clock (25 MHz pixel clock domain)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request pulse; honoured only when busy=0
- pos_x  input  10  current box left edge, screen pixel coordinates
- pos_y  input  10  current box top edge, screen pixel coordinates
- dx  input  4  signed proposed x move, -8..+7
- dy  input  4  signed proposed y move, -8..+7
- q_x  output  10  query x to level collision port, registered
- q_y  output  10  query y to level collision port, registered
- tile_hit  input  1  solid bit returned combinationally for (q_x,q_y); 1 for off-map
- busy  output  1  probe sequence in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- corner_hit  output  4  bit0 TL, bit1 TR, bit2 BL, bit3 BR
- hit_top, hit_bottom, hit_left, hit_right  output  1 each  edge ORs: TL|TR, BL|BR, TL|BL, TR|BR
- blocked  output  1  OR of corner_hit

Behaviour:
- Reset (async, rst_n=0): state IDLE; q_x=q_y=0; busy=0; done=0; corner_hit=0; all edge flags and blocked 0.
- Arithmetic:
  - nx = pos_x + sign_extend(dx); ny = pos_y + sign_extend(dy); all modulo 1024.
  - Far corners: nx+BOX_W-1 and ny+BOX_H-1, also modulo 1024.
  - No clamping. Wrapped coordinates land off-map, and tile_hit=1 marks them solid.
- FSM states: IDLE, Q_TL, Q_TR, Q_BL, Q_BR, DONE.
  - IDLE: on start, latch nx, ny, enter Q_TL, busy=1 next cycle. pos/dx/dy are sampled only at the start cycle.
  - Q_TL: q_x=nx, q_y=ny. Q_TR: q_x=nx+BOX_W-1, q_y=ny. Q_BL: q_x=nx, q_y=ny+BOX_H-1. Q_BR: q_x=nx+BOX_W-1, q_y=ny+BOX_H-1.
  - In each Q state, q_x/q_y already hold that corner (registered on entry). tile_hit is sampled at the end of the same cycle into the matching corner_hit bit.
  - After Q_BR, go to DONE: done=1 for one cycle, busy=0, results update; then return to IDLE.
- Latency:
  - start at cycle 0.
  - Queries at cycles 1-4.
  - done at cycle 5.
  - Next start accepted at cycle 5 (DONE accepts start, going directly to Q_TL).
- Result registers:
  - corner_hit, edge flags and blocked hold their last values until the next done.
  - Working bits are kept in a shadow register, so outputs never show a partial sequence.
- start while busy=1: ignored, no queueing.
- q_x/q_y hold their last value in IDLE/DONE.
- Reset mid-sequence: immediate return to IDLE, results cleared, no done pulse.
- tile_hit must be stable within the cycle. The probe assumes the map read is purely combinational, so there is no extra wait state.

Decomposition:
- Shared package: corner index constants (TL=0, TR=1, BL=2, BR=3), FSM state encoding, screen coordinate width (10).
- No sub-module; a single FSM with a corner offset mux is natural.

Test Plan:
- Empty map model (tile_hit=0 on-map), pos=(200,100), dx=+3, dy=-2, start: q sequence (203,98),(234,98),(203,129),(234,129) on cycles 1-4; done at cycle 5; corner_hit=0000, blocked=0.
- Model solid for x<175, pos=(150,100), dx=0, dy=0: corner_hit=0101, hit_left=1, hit_right=0, hit_top=1, hit_bottom=1, blocked=1.
- pos=(2,50), dx=-5, dy=0: nx wraps to 1021; TL/BL queries at x=1021, model returns 1 off-map, so corner_hit bits 0 and 2 set.
- start re-pulsed at cycles 2 and 3 of a running sequence: ignored, exactly one done at cycle 5. start at the done cycle launches a new sequence with Q_TL at cycle 6.
- rst_n low at cycle 3 of a sequence: busy=0 and corner_hit=0 immediately, no done pulse. A fresh start after release completes normally.
- Solid only at (234,129) region, pos=(200,100), dx=+3, dy=-2: corner_hit=1000, hit_bottom=1, hit_right=1, hit_top=0, hit_left=0. Prior results are held until done.

Source files
------------

// File: rtl/collision_probe_pkg.sv
// Shared constants for the collision probe: coordinate width, corner
// indices into corner_hit, and the probe FSM state encoding.
package collision_probe_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned CORNER_TL = 0;
    localparam int unsigned CORNER_TR = 1;
    localparam int unsigned CORNER_BL = 2;
    localparam int unsigned CORNER_BR = 3;

    typedef enum logic [2:0] {
        IDLE,
        Q_TL,
        Q_TR,
        Q_BL,
        Q_BR,
        DONE
    } probe_state_t;

endpackage

// File: rtl/collision_probe.sv
// Walks the four corners of the proposed player box through the level map's
// collision port, one per cycle, and reports corner and edge hits.
module collision_probe
    import collision_probe_pkg::*;
#(
    parameter int unsigned BOX_W = 32,
    parameter int unsigned BOX_H = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [3:0]         dx,
    input  logic [3:0]         dy,
    output logic [COORD_W-1:0] q_x,
    output logic [COORD_W-1:0] q_y,
    input  logic               tile_hit,
    output logic               busy,
    output logic               done,
    output logic [3:0]         corner_hit,
    output logic               hit_top,
    output logic               hit_bottom,
    output logic               hit_left,
    output logic               hit_right,
    output logic               blocked
);

    localparam logic [COORD_W-1:0] OFF_X = COORD_W'(BOX_W - 1);
    localparam logic [COORD_W-1:0] OFF_Y = COORD_W'(BOX_H - 1);

    probe_state_t state, state_nx;

    logic [COORD_W-1:0] nx_r, ny_r;
    logic [COORD_W-1:0] nx_c, ny_c;
    logic [COORD_W-1:0] far_x, far_y;
    logic [CORNER_BL:0] shadow;
    logic               take;

    // Coordinates wrap modulo 1024; wrapped corners land off-map and read solid.
    assign nx_c  = pos_x + {{(COORD_W-4){dx[3]}}, dx};
    assign ny_c  = pos_y + {{(COORD_W-4){dy[3]}}, dy};
    assign far_x = nx_r + OFF_X;
    assign far_y = ny_r + OFF_Y;

    assign take = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = Q_TL;
            Q_TL:    state_nx = Q_TR;
            Q_TR:    state_nx = Q_BL;
            Q_BL:    state_nx = Q_BR;
            Q_BR:    state_nx = DONE;
            DONE:    state_nx = take ? Q_TL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // q_x/q_y are loaded one cycle ahead so each Q state presents its own corner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nx_r       <= '0;
            ny_r       <= '0;
            q_x        <= '0;
            q_y        <= '0;
            shadow     <= '0;
            corner_hit <= '0;
        end else if (take) begin
            nx_r <= nx_c;
            ny_r <= ny_c;
            q_x  <= nx_c;
            q_y  <= ny_c;
        end else begin
            case (state)
                Q_TL: begin
                    shadow[CORNER_TL] <= tile_hit;
                    q_x               <= far_x;
                    q_y               <= ny_r;
                end
                Q_TR: begin
                    shadow[CORNER_TR] <= tile_hit;
                    q_x               <= nx_r;
                    q_y               <= far_y;
                end
                Q_BL: begin
                    shadow[CORNER_BL] <= tile_hit;
                    q_x               <= far_x;
                    q_y               <= far_y;
                end
                Q_BR: begin
                    corner_hit <= {tile_hit, shadow};
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state == Q_TL) || (state == Q_TR) ||
                        (state == Q_BL) || (state == Q_BR);
    assign done       = (state == DONE);
    assign hit_top    = corner_hit[CORNER_TL] | corner_hit[CORNER_TR];
    assign hit_bottom = corner_hit[CORNER_BL] | corner_hit[CORNER_BR];
    assign hit_left   = corner_hit[CORNER_TL] | corner_hit[CORNER_BL];
    assign hit_right  = corner_hit[CORNER_TR] | corner_hit[CORNER_BR];
    assign blocked    = |corner_hit;

endmodule
